// File: rtl/lstm_cell_update_pkg.sv
// lstm_cell_update_pkg: shared Q4.4 fixed-point constants and FSM state encoding
package lstm_cell_update_pkg;
  localparam int DW = 8;
  localparam int FRAC = 4;
  localparam int ONE = 16;
  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LATCH,
    S_CALC,
    S_WRITE,
    S_DONE
  } state_t;
endpackage

// File: rtl/lstm_fx_mac.sv
// lstm_fx_mac: combinational sat((a*b + c*d) >>> FRAC) in signed fixed point
module lstm_fx_mac
  import lstm_cell_update_pkg::*;
#(
  parameter int DW = lstm_cell_update_pkg::DW,
  parameter int FRAC = lstm_cell_update_pkg::FRAC
) (
  input  logic signed [DW-1:0] i_a,
  input  logic signed [DW-1:0] i_b,
  input  logic signed [DW-1:0] i_c,
  input  logic signed [DW-1:0] i_d,
  output logic signed [DW-1:0] o_y
);
  localparam logic signed [2*DW:0] MAXV = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW:0] MINV = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};
  logic signed [2*DW-1:0] w_p0, w_p1;
  logic signed [2*DW:0] w_sum, w_sh;
  assign w_p0 = i_a * i_b;
  assign w_p1 = i_c * i_d;
  assign w_sum = w_p0 + w_p1;
  assign w_sh = w_sum >>> FRAC;
  assign o_y = w_sh > MAXV ? MAXV[DW-1:0] : w_sh < MINV ? MINV[DW-1:0] : w_sh[DW-1:0];
endmodule

// File: rtl/lstm_cell_update.sv
// lstm_cell_update: sequential c[k] := sat(f*c + i*g) over N elements, 4 cycles each,
// read/latch/compute/write against external one-cycle-latency RAMs with four-phase req/ack.
module lstm_cell_update
  import lstm_cell_update_pkg::*;
#(
  parameter int N = 2,
  parameter int AW = 1,
  parameter int DW = lstm_cell_update_pkg::DW,
  parameter int FRAC = lstm_cell_update_pkg::FRAC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  output logic                 ack,
  output logic                 f_trig_r,
  output logic                 i_trig_r,
  output logic                 g_trig_r,
  output logic [AW-1:0]        f_abus_r,
  output logic [AW-1:0]        i_abus_r,
  output logic [AW-1:0]        g_abus_r,
  input  logic signed [DW-1:0] f_dbus_r,
  input  logic signed [DW-1:0] i_dbus_r,
  input  logic signed [DW-1:0] g_dbus_r,
  output logic                 c_trig_r,
  output logic [AW-1:0]        c_abus_r,
  input  logic signed [DW-1:0] c_dbus_r,
  output logic                 c_trig_w,
  output logic [AW-1:0]        c_abus_w,
  output logic signed [DW-1:0] c_dbus_w
);
  localparam logic [AW-1:0] K_LAST = AW'(N-1);
  state_t r_state, w_next;
  logic [AW-1:0] r_k;
  logic signed [DW-1:0] r_f, r_i, r_g, r_c, r_res, w_mac;
  logic w_rd, w_wr;
  lstm_fx_mac #(.DW(DW), .FRAC(FRAC)) u_mac (
    .i_a(r_f),
    .i_b(r_c),
    .i_c(r_i),
    .i_d(r_g),
    .o_y(w_mac)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = req ? S_ADDR : S_IDLE;
      S_ADDR:  w_next = S_LATCH;
      S_LATCH: w_next = S_CALC;
      S_CALC:  w_next = S_WRITE;
      S_WRITE: w_next = r_k == K_LAST ? S_DONE : S_ADDR;
      S_DONE:  w_next = req ? S_DONE : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k <= '0;
      r_f <= '0;
      r_i <= '0;
      r_g <= '0;
      r_c <= '0;
      r_res <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) r_k <= '0;
      else if (r_state == S_WRITE && r_k != K_LAST) r_k <= r_k + 1'b1;
      if (r_state == S_LATCH) begin
        r_f <= f_dbus_r;
        r_i <= i_dbus_r;
        r_g <= g_dbus_r;
        r_c <= c_dbus_r;
      end
      if (r_state == S_CALC) r_res <= w_mac;
    end
  end
  // outputs decode straight from state so an async reset clears them at once
  assign w_rd = r_state == S_ADDR;
  assign w_wr = r_state == S_WRITE;
  assign ack = r_state == S_DONE;
  assign f_trig_r = w_rd;
  assign i_trig_r = w_rd;
  assign g_trig_r = w_rd;
  assign c_trig_r = w_rd;
  assign f_abus_r = w_rd ? r_k : '0;
  assign i_abus_r = w_rd ? r_k : '0;
  assign g_abus_r = w_rd ? r_k : '0;
  assign c_abus_r = w_rd ? r_k : '0;
  assign c_trig_w = w_wr;
  assign c_abus_w = w_wr ? r_k : '0;
  assign c_dbus_w = w_wr ? r_res : '0;
endmodule
